// File: rtl/spi_temp_reader_if.sv
// spi_temp_reader_if: SPI bus (spi_sclk, spi_cs_n, spi_miso); master = reader side, slave = sensor side
interface spi_temp_reader_if;
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_miso;
  modport master (output spi_sclk, output spi_cs_n, input spi_miso);
  modport slave (input spi_sclk, input spi_cs_n, output spi_miso);
endinterface

// File: rtl/spi_temp_reader.sv
// spi_temp_reader: periodic SPI mode-0 sensor read, integer degC saturated to 0..99; ports clk, reset (sync active-low), en, spi (master modport), temp, temp_valid, busy; `SPI_TEMP_RAW_EN adds raw_frame, sat_flag
module spi_temp_reader #(
  parameter int CLK_DIV = 4,
  parameter int CONV_WAIT = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  spi_temp_reader_if.master spi,
  output logic [6:0]       temp,
  output logic             temp_valid,
`ifdef SPI_TEMP_RAW_EN
  output logic [15:0]      raw_frame,
  output logic             sat_flag,
`endif
  output logic             busy
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int WW = $clog2(CONV_WAIT + 1);
  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, LATCH, WAIT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [4:0] bit_cnt, bit_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic [15:0] sr, sr_n;
  logic sclk, sclk_n, cs_n, cs_n_n;
  logic [6:0] temp_n;
  logic [8:0] whole;
  logic last, wlast, neg, over;
  assign whole = sr[15:7];
  assign neg = whole[8];
  assign over = !neg && whole[7:0] > 8'd99;
  assign last = cnt == CW'(CLK_DIV - 1);
  assign wlast = wcnt == WW'(CONV_WAIT - 1);
  assign spi.spi_sclk = sclk;
  assign spi.spi_cs_n = cs_n;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    bit_n = bit_cnt;
    wcnt_n = wcnt;
    sr_n = sr;
    sclk_n = sclk;
    cs_n_n = cs_n;
    temp_n = temp;
    case (state)
      IDLE: begin
        state_n = en ? CS_SETUP : IDLE;
        cs_n_n = !en;
      end
      CS_SETUP: begin
        cnt_n = last ? '0 : cnt + 1'b1;
        state_n = last ? SHIFT : CS_SETUP;
      end
      SHIFT: begin
        cnt_n = last ? '0 : cnt + 1'b1;
        sclk_n = last ? !sclk : sclk;
        sr_n = last && !sclk ? {sr[14:0], spi.spi_miso} : sr;
        bit_n = last && !sclk ? bit_cnt + 1'b1 : bit_cnt;
        state_n = last && sclk && bit_cnt == 5'd16 ? CS_HOLD : SHIFT;
      end
      CS_HOLD: begin
        cnt_n = last ? '0 : cnt + 1'b1;
        state_n = last ? LATCH : CS_HOLD;
        cs_n_n = last;
      end
      LATCH: begin
        temp_n = neg ? 7'd0 : over ? 7'd99 : whole[6:0];
        bit_n = '0;
        state_n = WAIT;
      end
      WAIT: begin
        wcnt_n = wlast ? '0 : wcnt + 1'b1;
        state_n = wlast ? (en ? CS_SETUP : IDLE) : WAIT;
        cs_n_n = !(wlast && en);
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      wcnt <= '0;
      sr <= '0;
      sclk <= 1'b0;
      cs_n <= 1'b1;
      temp <= '0;
      temp_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_cnt <= bit_n;
      wcnt <= wcnt_n;
      sr <= sr_n;
      sclk <= sclk_n;
      cs_n <= cs_n_n;
      temp <= temp_n;
      temp_valid <= state == LATCH;
      busy <= state_n != IDLE && state_n != WAIT;
    end
  end
`ifdef SPI_TEMP_RAW_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      raw_frame <= '0;
      sat_flag <= 1'b0;
    end else if (state == LATCH) begin
      raw_frame <= sr;
      sat_flag <= neg || over;
    end
  end
`endif
endmodule

// File: tb/tb_spi_temp_reader.sv
// tb_spi_temp_reader: randomized sensor frames against an arithmetic reference model, plus SPI timing checks
module tb_spi_temp_reader;
  localparam int CLK_DIV = 4;
  localparam int CONV_WAIT = 10;
  logic clk = 0, reset = 0, en = 0;
  logic [6:0] temp;
  logic temp_valid, busy;
`ifdef SPI_TEMP_RAW_EN
  logic [15:0] raw_frame;
  logic sat_flag;
`endif
  int checks = 0, failures = 0;
  int cyc = 0, vcnt = 0, falls = 0, rises = 0, fall_t = 0, last_rise = 0, last_fall = 0;
  int f0, v0;
  int fall_q[$];
  logic [15:0] tx_q[$], exp_q[$];
  logic [15:0] fr, cur;
  logic prev_cs = 1, prev2_cs = 1, prev_sclk = 0, prev_valid = 0;
  logic [6:0] prev_temp = 0;
  spi_temp_reader_if spi();
  spi_temp_reader #(.CLK_DIV(CLK_DIV), .CONV_WAIT(CONV_WAIT)) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .spi(spi),
    .temp(temp),
    .temp_valid(temp_valid),
`ifdef SPI_TEMP_RAW_EN
    .raw_frame(raw_frame),
    .sat_flag(sat_flag),
`endif
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int whole_deg(input logic [15:0] f);
    int s;
    s = $signed(f);
    return $rtoi($floor(real'(s) / 128.0));
  endfunction
  function automatic int model_temp(input logic [15:0] f);
    int d;
    d = whole_deg(f);
    return d < 0 ? 0 : (d > 99 ? 99 : d);
  endfunction
  function automatic int model_sat(input logic [15:0] f);
    int d;
    d = whole_deg(f);
    return (d < 0 || d > 99) ? 1 : 0;
  endfunction
  function automatic logic [15:0] rand_frame();
    int k;
    logic [15:0] f;
    k = $urandom_range(0, 2);
    f = 16'($urandom);
    if (k == 0) f = 16'(($urandom_range(0, 99) << 7) | $urandom_range(0, 127));
    else if (k == 1) f[15] = 1'b1;
    return f;
  endfunction
  task automatic wait_valid(input int target);
    int budget;
    budget = 300 * (target - vcnt) + 100;
    for (int i = 0; i < budget && vcnt < target; i++) @(negedge clk);
    check("valid_count", vcnt, target);
  endtask
  task automatic wait_rises(input int base, input int n);
    for (int i = 0; i < 1000 && !(falls > base && rises >= n); i++) @(negedge clk);
    check("rise_wait", rises, n);
  endtask
  initial begin
    spi.spi_miso = 1'b0;
    forever begin
      @(negedge spi.spi_cs_n);
      cur = tx_q.size() > 0 ? tx_q.pop_front() : rand_frame();
      exp_q.push_back(cur);
      for (int b = 15; b >= 0; b--) begin
        spi.spi_miso = cur[b];
        if (b > 0) begin
          @(negedge spi.spi_sclk or posedge spi.spi_cs_n);
          if (spi.spi_cs_n) begin
            void'(exp_q.pop_back());
            break;
          end
        end
      end
    end
  end
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      check("sclk_idle", int'(spi.spi_sclk & spi.spi_cs_n), 0);
      if (prev_cs && !spi.spi_cs_n) begin
        falls++;
        fall_q.push_back(cyc);
        fall_t = cyc;
        rises = 0;
      end
      if (!prev_sclk && spi.spi_sclk) begin
        rises++;
        if (rises == 1) check("cs_to_first_rise", cyc - fall_t, 2 * CLK_DIV);
        else check("sclk_period", cyc - last_rise, 2 * CLK_DIV);
        last_rise = cyc;
      end
      if (prev_sclk && !spi.spi_sclk) last_fall = cyc;
      if (!prev_cs && spi.spi_cs_n && reset) begin
        check("rise_count", rises, 16);
        check("last_fall_to_cs", cyc - last_fall, CLK_DIV);
      end
      if (temp_valid) begin
        vcnt++;
        check("valid_width", int'(prev_valid), 0);
        check("valid_lag", int'({prev2_cs, prev_cs}), 1);
        if (exp_q.size() == 0) check("spurious_valid", int'(temp_valid), 0);
        else begin
          fr = exp_q.pop_front();
          check("temp", temp, model_temp(fr));
`ifdef SPI_TEMP_RAW_EN
          check("raw_frame", raw_frame, fr);
          check("sat_flag", sat_flag, model_sat(fr));
`endif
        end
      end else if (reset) check("temp_hold", temp, prev_temp);
      prev2_cs = prev_cs;
      prev_cs = spi.spi_cs_n;
      prev_sclk = spi.spi_sclk;
      prev_valid = temp_valid;
      prev_temp = temp;
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    check("rst_cs_n", spi.spi_cs_n, 1);
    check("rst_sclk", spi.spi_sclk, 0);
    check("rst_temp", temp, 0);
    check("rst_valid", temp_valid, 0);
    check("rst_busy", busy, 0);
    reset = 1;
    repeat (20) @(negedge clk);
    check("idle_no_cs", falls, 0);
    check("idle_busy", busy, 0);
    tx_q = '{16'h0C80, 16'hFB00, 16'h3C00, 16'h3180};
    en = 1;
    wait_valid(vcnt + 4);
    en = 0;
    repeat (40) @(negedge clk);
    f0 = fall_q.size();
    v0 = vcnt;
    tx_q = '{16'h0A00, 16'h0B00, 16'h0C80};
    en = 1;
    wait_valid(v0 + 3);
    en = 0;
    repeat (200) @(negedge clk);
    check("pulses3", vcnt - v0, 3);
    check("falls3", fall_q.size() - f0, 3);
    if (fall_q.size() >= f0 + 3)
      for (int i = 1; i < 3; i++) check("fall_to_fall", fall_q[f0+i] - fall_q[f0+i-1], CLK_DIV * 34 + 1 + CONV_WAIT);
    f0 = falls;
    v0 = vcnt;
    tx_q = '{16'h0C80};
    en = 1;
    wait_rises(f0, 5);
    en = 0;
    wait_valid(v0 + 1);
    repeat (300) @(negedge clk);
    check("drop_falls", falls - f0, 1);
    check("drop_busy", busy, 0);
    check("drop_temp", temp, 25);
    f0 = falls;
    tx_q.push_back(rand_frame());
    en = 1;
    wait_rises(f0, 7);
    reset = 0;
    @(negedge clk);
    check("midrst_cs_n", spi.spi_cs_n, 1);
    check("midrst_sclk", spi.spi_sclk, 0);
    check("midrst_temp", temp, 0);
    check("midrst_busy", busy, 0);
    repeat (2) @(negedge clk);
    v0 = vcnt;
    tx_q.push_back(rand_frame());
    reset = 1;
    wait_valid(v0 + 1);
    en = 0;
    repeat (40) @(negedge clk);
    v0 = vcnt;
    for (int i = 0; i < 8; i++) tx_q.push_back(rand_frame());
    en = 1;
    wait_valid(v0 + 8);
    en = 0;
    repeat (40) @(negedge clk);
    check("exp_drained", exp_q.size(), 0);
    check("final_busy", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
